gpc_mc: RTL and testbench

GPC_MC -- requirements
Module: gpc_mc

---
 rtl/gpc_pkg.sv | 69 ++++++
 rtl/gpc_regfile.sv | 46 ++++
 rtl/gpc_mc.sv | 232 +++++++++++++++++++++++
 tb/tb_gpc_mc.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/gpc_pkg.sv
// gpc_pkg: shared definitions for the gpc_mc multi-cycle RV32I/E core.
//   - RV32 opcode, funct3 and funct7 constants for the supported subset
//   - FSM state enum (StFetch, StExec, StHalt)
//   - ALU operation enum and the ALU evaluation function
package gpc_pkg;

    // Major opcodes
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3SrlSra = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    localparam logic [31:0] EbreakInst = 32'h0010_0073;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StHalt
    } gpc_state_e;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd
    } alu_op_e;

    function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] res;
        unique case (op)
            AluAdd:  res = a + b;
            AluSub:  res = a - b;
            AluSll:  res = a << b[4:0];
            AluSlt:  res = {31'b0, $signed(a) < $signed(b)};
            AluSltu: res = {31'b0, a < b};
            AluXor:  res = a ^ b;
            AluSrl:  res = a >> b[4:0];
            AluSra:  res = $signed(a) >>> b[4:0];
            AluOr:   res = a | b;
            AluAnd:  res = a & b;
            default: res = a + b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/gpc_regfile.sv
// gpc_regfile: NREG x 32-bit general-purpose registers, x0 hardwired to zero.
//   clk, rst            clock, asynchronous active-low reset (clears all registers)
//   raddr1/rdata1       combinational read port 1
//   raddr2/rdata2       combinational read port 2
//   we/waddr/wdata      synchronous write port (writes to x0 are dropped)
//   a0                  live value of x10
// Only the low $clog2(NREG) index bits are decoded, so with NREG=16 bit 4 is ignored.
module gpc_regfile #(
    parameter int unsigned NREG = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] a0
);

    localparam int unsigned AW = $clog2(NREG);

    logic [31:0] regs_q [1:NREG-1];

    logic [AW-1:0] ra1, ra2, wa;
    assign ra1 = raddr1[AW-1:0];
    assign ra2 = raddr2[AW-1:0];
    assign wa  = waddr[AW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
        end else if (we) begin
            for (int i = 1; i < NREG; i++) begin
                if (wa == AW'(i)) regs_q[i] <= wdata;
            end
        end
    end

    assign rdata1 = (ra1 == '0) ? '0 : regs_q[ra1];
    assign rdata2 = (ra2 == '0) ? '0 : regs_q[ra2];
    assign a0     = regs_q[10];

endmodule

// File: rtl/gpc_mc.sv
// gpc_mc: minimal multi-cycle RV32I/RV32E core (FETCH -> EXEC, >= 2 cycles/instr).
//   clk, rst        clock, asynchronous active-low reset
//   inst_req, pc    fetch request and the address being fetched
//   inst_valid,inst instruction word returned for pc (only sampled in FETCH)
//   retire          one-cycle pulse per completed instruction
//   a0              live value of x10
//   ebreak          sticky, set when EBREAK executes (core halts)
//   illegal         sticky illegal-instruction flag, only with GPC_ILLEGAL_TRAP_EN
// Build option: `define GPC_ILLEGAL_TRAP_EN to trap (halt) on unsupported encodings or
// register indices >= NREG; otherwise those encodings retire as NOPs.
module gpc_mc
    import gpc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned NREG     = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [31:0] pc,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        retire,
    output logic [31:0] a0,
`ifdef GPC_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic        ebreak
);

    gpc_state_e  state_q;
    logic [31:0] pc_q, ir_q;
    logic        inst_req_q, retire_q, ebreak_q;

    // Instruction fields
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    logic [31:0] i_imm, u_imm, j_imm;
    assign i_imm = {{20{ir_q[31]}}, ir_q[31:20]};
    assign u_imm = {ir_q[31:12], 12'b0};
    assign j_imm = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    logic [31:0] rs1_data, rs2_data, pc_plus4;
    assign pc_plus4 = pc_q + 32'd4;

    // Decode
    alu_op_e     alu_op;
    logic [31:0] op_a, op_b, jalr_sum, next_pc, wdata;
    logic        wen, link, is_ebreak, enc_ok, legal;

    assign jalr_sum = rs1_data + i_imm;

    always_comb begin
        alu_op    = AluAdd;
        op_a      = rs1_data;
        op_b      = i_imm;
        wen       = 1'b0;
        link      = 1'b0;
        is_ebreak = 1'b0;
        enc_ok    = 1'b1;
        next_pc   = pc_plus4;
        unique case (opcode)
            OpLui: begin
                op_a = '0;
                op_b = u_imm;
                wen  = 1'b1;
            end
            OpAuipc: begin
                op_a = pc_q;
                op_b = u_imm;
                wen  = 1'b1;
            end
            OpJal: begin
                wen     = 1'b1;
                link    = 1'b1;
                next_pc = pc_q + j_imm;
            end
            OpJalr: begin
                wen     = 1'b1;
                link    = 1'b1;
                enc_ok  = (funct3 == 3'b000);
                next_pc = {jalr_sum[31:1], 1'b0};
            end
            OpImm: begin
                wen = 1'b1;
                unique case (funct3)
                    F3AddSub: alu_op = AluAdd;
                    F3Slt:    alu_op = AluSlt;
                    F3Sltu:   alu_op = AluSltu;
                    F3Xor:    alu_op = AluXor;
                    F3Or:     alu_op = AluOr;
                    F3And:    alu_op = AluAnd;
                    F3Sll: begin
                        alu_op = AluSll;
                        enc_ok = (funct7 == F7Base);
                    end
                    F3SrlSra: begin
                        alu_op = (funct7 == F7Alt) ? AluSra : AluSrl;
                        enc_ok = (funct7 == F7Base) || (funct7 == F7Alt);
                    end
                    default: enc_ok = 1'b0;
                endcase
            end
            OpReg: begin
                wen  = 1'b1;
                op_b = rs2_data;
                if (funct7 == F7Base) begin
                    unique case (funct3)
                        F3AddSub: alu_op = AluAdd;
                        F3Sll:    alu_op = AluSll;
                        F3Slt:    alu_op = AluSlt;
                        F3Sltu:   alu_op = AluSltu;
                        F3Xor:    alu_op = AluXor;
                        F3SrlSra: alu_op = AluSrl;
                        F3Or:     alu_op = AluOr;
                        F3And:    alu_op = AluAnd;
                        default:  enc_ok = 1'b0;
                    endcase
                end else if (funct7 == F7Alt && funct3 == F3AddSub) begin
                    alu_op = AluSub;
                end else if (funct7 == F7Alt && funct3 == F3SrlSra) begin
                    alu_op = AluSra;
                end else begin
                    enc_ok = 1'b0;
                end
            end
            OpSystem: begin
                if (ir_q == EbreakInst) is_ebreak = 1'b1;
                else                    enc_ok    = 1'b0;
            end
            default: enc_ok = 1'b0;
        endcase
    end

    assign wdata = link ? pc_plus4 : alu_calc(alu_op, op_a, op_b);

`ifdef GPC_ILLEGAL_TRAP_EN
    logic illegal_q, bad_idx, use_rd, use_rs1, use_rs2;

    always_comb begin
        use_rd  = (opcode == OpLui) || (opcode == OpAuipc) || (opcode == OpJal) ||
                  (opcode == OpJalr) || (opcode == OpImm) || (opcode == OpReg);
        use_rs1 = (opcode == OpJalr) || (opcode == OpImm) || (opcode == OpReg);
        use_rs2 = (opcode == OpReg);
        // Only RV32E can have out-of-range indices (bit 4 set)
        bad_idx = (NREG < 32) &&
                  ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));
    end

    assign legal   = enc_ok && !bad_idx;
    assign illegal = illegal_q;
`else
    assign legal = enc_ok;
`endif

    logic rf_we;
    assign rf_we = (state_q == StExec) && wen && legal && !is_ebreak;

    gpc_regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .rdata1 (rs1_data),
        .raddr2 (rs2),
        .rdata2 (rs2_data),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (wdata),
        .a0     (a0)
    );

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            inst_req_q <= 1'b1;
            retire_q   <= 1'b0;
            ebreak_q   <= 1'b0;
`ifdef GPC_ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            retire_q <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    if (inst_valid) begin
                        ir_q       <= inst;
                        inst_req_q <= 1'b0;
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    if (is_ebreak) begin
                        ebreak_q <= 1'b1;
                        state_q  <= StHalt;
`ifdef GPC_ILLEGAL_TRAP_EN
                    end else if (!legal) begin
                        illegal_q <= 1'b1;
                        state_q   <= StHalt;
`endif
                    end else begin
                        // Unsupported encodings land here only without the trap build: NOP
                        pc_q       <= legal ? next_pc : pc_plus4;
                        retire_q   <= 1'b1;
                        inst_req_q <= 1'b1;
                        state_q    <= StFetch;
                    end
                end
                StHalt: ;
                default: state_q <= StHalt;
            endcase
        end
    end

    assign inst_req = inst_req_q;
    assign pc       = pc_q;
    assign retire   = retire_q;
    assign ebreak   = ebreak_q;

endmodule

// File: tb/tb_gpc_mc.sv
// tb_gpc_mc: directed self-checking bench for gpc_mc with hand-computed expectations.
// Works in both builds; the GPC_ILLEGAL_TRAP_EN path is selected with the same macro.
module tb_gpc_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req;
    logic [31:0] pc;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        retire;
    logic [31:0] a0;
    logic        ebreak;
`ifdef GPC_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gpc_mc #(
        .RESET_PC (32'h8000_0000),
        .NREG     (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .pc         (pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .retire     (retire),
        .a0         (a0),
`ifdef GPC_ILLEGAL_TRAP_EN
        .illegal    (illegal),
`endif
        .ebreak     (ebreak)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // Feed one instruction; returns #1 after the EXEC edge.
    task automatic run_inst(input logic [31:0] w);
        int n = 0;
        while (!inst_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("fetch_ready", {31'b0, inst_req}, 32'd1);
        inst_valid = 1'b1;
        inst       = w;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst       = '0;
        @(posedge clk);
        #1;
    endtask

    // Run one instruction expected to retire, then check pc and a0.
    task automatic step(input string tag, input logic [31:0] w, input logic [31:0] exp_pc,
                        input logic [31:0] exp_a0);
        run_inst(w);
        check({tag, "_retire"}, {31'b0, retire}, 32'd1);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_a0"}, a0, exp_a0);
    endtask

    initial begin
        do_reset();
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst_req", {31'b0, inst_req}, 32'd1);
        check("rst_a0", a0, 32'd0);
        check("rst_retire", {31'b0, retire}, 32'd0);
        check("rst_ebreak", {31'b0, ebreak}, 32'd0);

        // Fetch stall
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_pc", pc, 32'h8000_0000);
            check("stall_retire", {31'b0, retire}, 32'd0);
        end

        step("addi7", 32'h0070_0513, 32'h8000_0004, 32'd7);
        @(posedge clk);
        #1;
        check("retire_pulse_end", {31'b0, retire}, 32'd0);

        // Reset during EXEC drops the in-flight instruction
        inst_valid = 1'b1;
        inst       = 32'h0090_0513;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        rst        = 1'b0;
        #1;
        check("midrst_pc", pc, 32'h8000_0000);
        check("midrst_inst_req", {31'b0, inst_req}, 32'd1);
        check("midrst_a0", a0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_a0_after", a0, 32'd0);

        step("jal", 32'h0080_00EF, 32'h8000_0008, 32'd0);
        step("mv_a0_x1", 32'h0000_8513, 32'h8000_000C, 32'h8000_0004);
        step("lui", 32'h1234_5537, 32'h8000_0010, 32'h1234_5000);
        step("addi_neg1", 32'hFFF5_0513, 32'h8000_0014, 32'h1234_4FFF);
        step("addi_m16", 32'hFF00_0513, 32'h8000_0018, 32'hFFFF_FFF0);
        step("srai", 32'h4025_5513, 32'h8000_001C, 32'hFFFF_FFFC);
        step("srli", 32'h01C5_5513, 32'h8000_0020, 32'h0000_000F);
        step("sltiu", 32'hFFF5_3513, 32'h8000_0024, 32'd1);
        step("sub", 32'h40A0_0533, 32'h8000_0028, 32'hFFFF_FFFF);
        step("slt", 32'h0005_2533, 32'h8000_002C, 32'd1);
        step("wr_x0", 32'h0050_0013, 32'h8000_0030, 32'd1);
        step("add_x0", 32'h0000_0533, 32'h8000_0034, 32'd0);
        step("auipc", 32'h0000_1517, 32'h8000_0038, 32'h8000_1034);
        step("addi_odd", 32'h1010_0513, 32'h8000_003C, 32'h0000_0101);
        step("jalr_same", 32'h0005_0567, 32'h0000_0100, 32'h8000_0040);

        // EBREAK halts; later inst_valid is ignored
        run_inst(32'h0010_0073);
        check("ebreak_flag", {31'b0, ebreak}, 32'd1);
        check("ebreak_req", {31'b0, inst_req}, 32'd0);
        check("ebreak_retire", {31'b0, retire}, 32'd0);
        check("ebreak_pc", pc, 32'h0000_0100);
        inst_valid = 1'b1;
        inst       = 32'h0070_0513;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("halt_pc", pc, 32'h0000_0100);
            check("halt_a0", a0, 32'h8000_0040);
            check("halt_retire", {31'b0, retire}, 32'd0);
            check("halt_ebreak", {31'b0, ebreak}, 32'd1);
        end
        inst_valid = 1'b0;

        do_reset();
        check("rst2_ebreak", {31'b0, ebreak}, 32'd0);
        check("rst2_pc", pc, 32'h8000_0000);

        run_inst(32'hFFFF_FFFF);
`ifdef GPC_ILLEGAL_TRAP_EN
        check("ill_flag", {31'b0, illegal}, 32'd1);
        check("ill_req", {31'b0, inst_req}, 32'd0);
        check("ill_retire", {31'b0, retire}, 32'd0);
        check("ill_pc", pc, 32'h8000_0000);
`else
        check("ill_retire", {31'b0, retire}, 32'd1);
        check("ill_pc", pc, 32'h8000_0004);
        check("ill_a0", a0, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
